// File: rtl/acc_pkg.sv
// Shared types and constants for the Cohort accelerator configuration path.
//   cfg_word_t       : one 64-bit configuration word
//   cfg_state_e      : loader run state (IDLE / PENDING / ACTIVE)
//   Status*          : bit positions inside the STATUS read word
//   commit_addr()    : word address of COMMIT/STATUS, given the word count
//   clear_err_addr() : word address of CLEAR_ERR, given the word count
package acc_pkg;

    typedef logic [63:0] cfg_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACTIVE  = 2'd2
    } cfg_state_e;

    localparam int unsigned StatusBusyBit    = 0;
    localparam int unsigned StatusErrBit     = 1;
    localparam int unsigned StatusCountLsb   = 16;
    localparam int unsigned StatusCountWidth = 32;

    function automatic int unsigned commit_addr(input int unsigned num_words);
        return num_words;
    endfunction

    function automatic int unsigned clear_err_addr(input int unsigned num_words);
        return num_words + 1;
    endfunction

endpackage

// File: rtl/cohort_cfg_regfile.sv
// Shadow configuration registers plus the registered MMIO read path.
//   clk_i, rst_ni            : clock, async active-low reset
//   wr_valid_i/addr/data     : MMIO write (only shadow word addresses act here)
//   rd_valid_i, rd_addr_i    : MMIO read request
//   status_i                 : STATUS word supplied by the top, muxed at the COMMIT address
//   rd_valid_o, rd_data_o    : read response, one cycle after the request
//   shadow_o                 : all shadow words flattened, word 0 in the LSBs
module cohort_cfg_regfile
    import acc_pkg::*;
#(
    parameter int unsigned NumCfgWords = 4,
    parameter int unsigned AddrWidth   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_valid_i,
    input  logic [AddrWidth-1:0]      wr_addr_i,
    input  logic [63:0]               wr_data_i,
    input  logic                      rd_valid_i,
    input  logic [AddrWidth-1:0]      rd_addr_i,
    input  cfg_word_t                 status_i,
    output logic                      rd_valid_o,
    output logic [63:0]               rd_data_o,
    output logic [NumCfgWords*64-1:0] shadow_o
);

    logic [NumCfgWords*64-1:0] shadow_flat;
    cfg_word_t                 rd_data_next;
    cfg_word_t                 rd_data_reg;
    logic                      rd_valid_reg;

    generate
        for (genvar gi = 0; gi < NumCfgWords; gi++) begin : g_word
            cfg_word_t word_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    word_reg <= '0;
                end else if (wr_valid_i && (wr_addr_i == AddrWidth'(gi))) begin
                    word_reg <= wr_data_i;
                end
            end

            assign shadow_flat[gi*64 +: 64] = word_reg;
        end
    endgenerate

    // Read mux sees pre-write values, so a same-cycle write/read returns old data.
    always_comb begin
        rd_data_next = '0;
        for (int i = 0; i < int'(NumCfgWords); i++) begin
            if (rd_addr_i == AddrWidth'(i)) begin
                rd_data_next = shadow_flat[i*64 +: 64];
            end
        end
        if (rd_addr_i == AddrWidth'(commit_addr(NumCfgWords))) begin
            rd_data_next = status_i;
        end
    end

    // Data only updates on a request so the last response stays visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_valid_i;
            if (rd_valid_i) begin
                rd_data_reg <= rd_data_next;
            end
        end
    end

    assign rd_valid_o = rd_valid_reg;
    assign rd_data_o  = rd_data_reg;
    assign shadow_o   = shadow_flat;

endmodule

// File: rtl/cohort_acc_cfg_loader.sv
// Configuration front-end for a Cohort accelerator tile.
// Software fills shadow words over MMIO, COMMIT snapshots them into the active
// register, the snapshot is offered over cfg_valid/cfg_ready, and the run is
// tracked until acc_done_i.
//   clk_i, rst_ni                  : clock, async active-low reset
//   wr_valid_i/wr_ready_o/addr/data: MMIO write port (always ready)
//   rd_valid_i/rd_addr_i           : MMIO read request
//   rd_valid_o/rd_data_o           : registered read response
//   cfg_valid_o/cfg_ready_i        : snapshot handshake to the accelerator
//   cfg_data_o                     : active snapshot, word 0 in the LSBs
//   acc_done_i                     : accelerator finished the current run
//   busy_o                         : a snapshot is pending or running
//   done_irq_o                     : one-cycle pulse per completed run
module cohort_acc_cfg_loader
    import acc_pkg::*;
#(
    parameter int unsigned NumCfgWords = 4,
    parameter int unsigned AddrWidth   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [AddrWidth-1:0]      wr_addr_i,
    input  logic [63:0]               wr_data_i,
    input  logic                      rd_valid_i,
    input  logic [AddrWidth-1:0]      rd_addr_i,
    output logic                      rd_valid_o,
    output logic [63:0]               rd_data_o,
    output logic                      cfg_valid_o,
    input  logic                      cfg_ready_i,
    output logic [NumCfgWords*64-1:0] cfg_data_o,
    input  logic                      acc_done_i,
    output logic                      busy_o,
    output logic                      done_irq_o
);

    cfg_state_e                state_reg, state_next;
    logic [NumCfgWords*64-1:0] shadow_flat;
    logic [NumCfgWords*64-1:0] active_reg;
    logic                      err_reg;
    logic [31:0]               done_count_reg;
    logic                      done_irq_reg;
    cfg_word_t                 status_word;

    logic commit_wr, clear_wr, bad_addr_wr;
    logic cfg_valid, busy, snapshot_en, commit_reject, run_done;

    assign commit_wr   = wr_valid_i && (wr_addr_i == AddrWidth'(commit_addr(NumCfgWords)));
    assign clear_wr    = wr_valid_i && (wr_addr_i == AddrWidth'(clear_err_addr(NumCfgWords)));
    assign bad_addr_wr = wr_valid_i && (wr_addr_i > AddrWidth'(clear_err_addr(NumCfgWords)));

    cohort_cfg_regfile #(
        .NumCfgWords (NumCfgWords),
        .AddrWidth   (AddrWidth)
    ) u_regfile (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_valid_i (wr_valid_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rd_valid_i (rd_valid_i),
        .rd_addr_i  (rd_addr_i),
        .status_i   (status_word),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .shadow_o   (shadow_flat)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (commit_wr)   state_next = PENDING;
            PENDING: if (cfg_ready_i) state_next = ACTIVE;
            ACTIVE:  if (acc_done_i)  state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Outputs / events decoded from the current state
    always_comb begin
        cfg_valid     = (state_reg == PENDING);
        busy          = (state_reg != IDLE);
        snapshot_en   = (state_reg == IDLE) && commit_wr;
        commit_reject = (state_reg != IDLE) && commit_wr;
        run_done      = (state_reg == ACTIVE) && acc_done_i;
    end

    // Snapshot, error flag, completion counter and irq pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_reg     <= '0;
            err_reg        <= 1'b0;
            done_count_reg <= '0;
            done_irq_reg   <= 1'b0;
        end else begin
            if (snapshot_en) begin
                active_reg <= shadow_flat;
            end
            // An error event in the same cycle as CLEAR_ERR leaves err set.
            if (bad_addr_wr || commit_reject) begin
                err_reg <= 1'b1;
            end else if (clear_wr) begin
                err_reg <= 1'b0;
            end
            if (run_done) begin
                done_count_reg <= done_count_reg + 32'd1;
            end
            done_irq_reg <= run_done;
        end
    end

    always_comb begin
        status_word                                     = '0;
        status_word[StatusBusyBit]                      = busy;
        status_word[StatusErrBit]                       = err_reg;
        status_word[StatusCountLsb +: StatusCountWidth] = done_count_reg;
    end

    assign wr_ready_o  = 1'b1;
    assign cfg_valid_o = cfg_valid;
    assign cfg_data_o  = active_reg;
    assign busy_o      = busy;
    assign done_irq_o  = done_irq_reg;

endmodule

// File: tb/tb_cohort_acc_cfg_loader.sv
module tb_cohort_acc_cfg_loader;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int COMMIT_A = N;
    localparam int CLEAR_A  = N + 1;

    logic            clk;
    logic            rst_n;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr;
    logic [63:0]     wr_data;
    logic            rd_valid;
    logic [AW-1:0]   rd_addr;
    logic            rd_valid_q;
    logic [63:0]     rd_data;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [N*64-1:0] cfg_data;
    logic            acc_done;
    logic            busy;
    logic            done_irq;

    cohort_acc_cfg_loader #(.NumCfgWords(N), .AddrWidth(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_valid_i  (rd_valid),
        .rd_addr_i   (rd_addr),
        .rd_valid_o  (rd_valid_q),
        .rd_data_o   (rd_data),
        .cfg_valid_o (cfg_valid),
        .cfg_ready_i (cfg_ready),
        .cfg_data_o  (cfg_data),
        .acc_done_i  (acc_done),
        .busy_o      (busy),
        .done_irq_o  (done_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Behavioural model: software-visible state as plain variables.
    logic [63:0]     m_shadow [N];
    logic [N*64-1:0] m_active;
    bit              m_offered;   // snapshot waiting for the accelerator
    bit              m_running;   // accelerator owns the snapshot
    bit              m_err;
    int unsigned     m_count;
    bit              m_irq;
    bit              m_rd_valid;
    logic [63:0]     m_rd_data;

    function automatic logic [63:0] exp_status();
        return (64'(m_count) << 16) | (64'(m_err) << 1) | 64'(m_offered | m_running);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_shadow[i] = '0;
        m_active = '0; m_offered = 0; m_running = 0; m_err = 0;
        m_count = 0; m_irq = 0; m_rd_valid = 0; m_rd_data = '0;
    endtask

    // Advance one clock, updating the model from the inputs seen at that edge.
    task automatic cycle();
        bit was_offered, was_running, err_set;
        int a;
        was_offered = m_offered;
        was_running = m_running;
        err_set = 0;
        m_rd_valid = rd_valid;
        if (rd_valid) begin
            a = int'(rd_addr);
            if (a < N)              m_rd_data = m_shadow[a];
            else if (a == COMMIT_A) m_rd_data = exp_status();
            else                    m_rd_data = '0;
        end
        m_irq = 0;
        if (was_running && acc_done) begin
            m_running = 0; m_count = m_count + 1; m_irq = 1;
        end
        if (was_offered && cfg_ready) begin
            m_offered = 0; m_running = 1;
        end
        if (wr_valid) begin
            a = int'(wr_addr);
            if (a < N) m_shadow[a] = wr_data;
            else if (a == COMMIT_A) begin
                if (!was_offered && !was_running) begin
                    for (int i = 0; i < N; i++) m_active[i*64 +: 64] = m_shadow[i];
                    m_offered = 1;
                end else err_set = 1;
            end
            else if (a == CLEAR_A) begin
                if (!err_set) m_err = 0;
            end
            else err_set = 1;
        end
        if (err_set) m_err = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cycle(input int a, input logic [63:0] d);
        wr_valid = 1; wr_addr = AW'(a); wr_data = d;
        cycle();
        wr_valid = 0;
    endtask

    task automatic rd_cycle(input int a);
        rd_valid = 1; rd_addr = AW'(a);
        cycle();
        rd_valid = 0;
    endtask

    task automatic test_reset();
        tests_run++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %0b exp 1", wr_ready); end
        tests_run++; if (rd_valid_q !== 1'b0 || rd_data !== 64'd0) begin fails++; $display("FAIL reset_rd got v=%0b d=%h exp 0", rd_valid_q, rd_data); end
        tests_run++; if (cfg_valid !== 1'b0 || busy !== 1'b0 || done_irq !== 1'b0) begin fails++; $display("FAIL reset_ctrl got v=%0b b=%0b i=%0b exp 0", cfg_valid, busy, done_irq); end
        tests_run++; if (cfg_data !== '0) begin fails++; $display("FAIL reset_cfg_data got %h exp 0", cfg_data); end
        rd_cycle(COMMIT_A);
        tests_run++; if (rd_valid_q !== 1'b1 || rd_data !== 64'd0) begin fails++; $display("FAIL reset_status got v=%0b d=%h exp 1/0", rd_valid_q, rd_data); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic_commit();
        for (int i = 0; i < N; i++) wr_cycle(i, 64'hA + 64'(i));
        cfg_ready = 1;
        wr_cycle(COMMIT_A, 64'($urandom));
        tests_run++; if (cfg_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL commit_valid got v=%0b b=%0b exp 1/1", cfg_valid, busy); end
        tests_run++; if (cfg_data !== m_active || cfg_data[63:0] !== 64'hA || cfg_data[N*64-1 -: 64] !== 64'hD) begin fails++; $display("FAIL commit_data got %h exp %h", cfg_data, m_active); end
        cycle();
        cfg_ready = 0;
        tests_run++; if (cfg_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL commit_one_cycle got v=%0b b=%0b exp 0/1", cfg_valid, busy); end
        $display("[TB] test_basic_commit done");
    endtask

    task automatic test_completion(input int runs);
        for (int r = 0; r < runs; r++) begin
            if (!m_running) begin
                for (int i = 0; i < N; i++) wr_cycle(i, {$urandom, $urandom});
                cfg_ready = 1; wr_cycle(COMMIT_A, 64'd0); cycle(); cfg_ready = 0;
            end
            repeat ($urandom_range(0, 3)) cycle();
            acc_done = 1; cycle(); acc_done = 0;
            tests_run++; if (done_irq !== 1'b1 || busy !== 1'b0 || m_irq != 1'b1) begin fails++; $display("FAIL done_pulse got i=%0b b=%0b exp 1/0", done_irq, busy); end
            rd_cycle(COMMIT_A);
            tests_run++; if (done_irq !== 1'b0) begin fails++; $display("FAIL done_pulse_width got %0b exp 0", done_irq); end
            tests_run++; if (rd_data !== m_rd_data) begin fails++; $display("FAIL done_status got %h exp %h", rd_data, m_rd_data); end
            $display("[TB] run complete, done_count exp %0d", m_count);
        end
    endtask

    task automatic test_backpressure();
        logic [N*64-1:0] held;
        for (int i = 0; i < N; i++) wr_cycle(i, 64'hA + 64'(i));
        cfg_ready = 0;
        wr_cycle(COMMIT_A, 64'd0);
        held = m_active;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) wr_cycle(0, 64'hFF); else cycle();
            tests_run++; if (cfg_valid !== 1'b1 || cfg_data !== held || cfg_data[63:0] !== 64'hA) begin fails++; $display("FAIL bp_hold c=%0d got v=%0b w0=%h exp 1/a", c, cfg_valid, cfg_data[63:0]); end
        end
        cfg_ready = 1;
        cycle();
        tests_run++; if (cfg_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL bp_handshake got v=%0b b=%0b exp 0/1", cfg_valid, busy); end
        repeat (3) cycle();
        tests_run++; if (cfg_valid !== 1'b0) begin fails++; $display("FAIL bp_once got %0b exp 0", cfg_valid); end
        cfg_ready = 0;
        rd_cycle(0);
        tests_run++; if (rd_data !== m_rd_data || rd_data !== 64'hFF) begin fails++; $display("FAIL bp_shadow got %h exp ff", rd_data); end
        acc_done = 1; cycle(); acc_done = 0;
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_errors();
        logic [N*64-1:0] held;
        cfg_ready = 1; wr_cycle(COMMIT_A, 64'd0); cycle(); cfg_ready = 0;
        held = m_active;
        wr_cycle(0, {$urandom, $urandom});
        wr_cycle(COMMIT_A, 64'd0);
        tests_run++; if (busy !== 1'b1 || cfg_valid !== 1'b0 || cfg_data !== held) begin fails++; $display("FAIL err_commit_state got b=%0b v=%0b exp 1/0", busy, cfg_valid); end
        rd_cycle(COMMIT_A);
        tests_run++; if (rd_data !== m_rd_data || rd_data[1] !== 1'b1) begin fails++; $display("FAIL err_commit_flag got %h exp %h", rd_data, m_rd_data); end
        acc_done = 1; cycle(); acc_done = 0;
        wr_cycle(CLEAR_A, 64'd0);
        rd_cycle(COMMIT_A);
        tests_run++; if (rd_data !== m_rd_data || rd_data[1] !== 1'b0) begin fails++; $display("FAIL err_clear got %h exp %h", rd_data, m_rd_data); end
        wr_cycle(N + 2, 64'd1);
        rd_cycle(COMMIT_A);
        tests_run++; if (rd_data !== m_rd_data || rd_data[1] !== 1'b1) begin fails++; $display("FAIL err_bad_addr got %h exp %h", rd_data, m_rd_data); end
        wr_cycle(CLEAR_A, 64'd0);
        wr_cycle(31, 64'd2);
        rd_cycle(COMMIT_A);
        tests_run++; if (rd_data !== m_rd_data || rd_data[1] !== 1'b1) begin fails++; $display("FAIL err_clear_then_bad got %h exp %h", rd_data, m_rd_data); end
        rd_cycle(CLEAR_A);
        tests_run++; if (rd_data !== 64'd0) begin fails++; $display("FAIL err_clear_read got %h exp 0", rd_data); end
        wr_cycle(CLEAR_A, 64'd0);
        $display("[TB] test_errors done");
    endtask

    task automatic test_stray_done();
        int unsigned cnt;
        cnt = m_count;
        acc_done = 1; cycle(); acc_done = 0;
        tests_run++; if (done_irq !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stray_idle got i=%0b b=%0b exp 0/0", done_irq, busy); end
        cfg_ready = 0; wr_cycle(COMMIT_A, 64'd0);
        cfg_ready = 1; acc_done = 1; cycle(); cfg_ready = 0; acc_done = 0;
        tests_run++; if (done_irq !== 1'b0 || busy !== 1'b1 || cfg_valid !== 1'b0) begin fails++; $display("FAIL stray_hs got i=%0b b=%0b v=%0b exp 0/1/0", done_irq, busy, cfg_valid); end
        rd_cycle(COMMIT_A);
        tests_run++; if (done_irq !== 1'b0 || rd_data !== m_rd_data || m_count != cnt) begin fails++; $display("FAIL stray_count got %h exp %h", rd_data, m_rd_data); end
        acc_done = 1; cycle(); acc_done = 0;
        tests_run++; if (done_irq !== 1'b1) begin fails++; $display("FAIL stray_real_done got %0b exp 1", done_irq); end
        $display("[TB] test_stray_done done");
    endtask

    task automatic test_random_rw(input int iters);
        int wa, ra;
        for (int k = 0; k < iters; k++) begin
            wa = $urandom_range(0, 6);
            if (wa >= N) wa = wa + 1;            // skip COMMIT: shadow, CLEAR_ERR or bad
            ra = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) ra = wa;  // same-address write/read
            wr_valid = ($urandom_range(0, 1) == 1); wr_addr = AW'(wa); wr_data = {$urandom, $urandom};
            rd_valid = ($urandom_range(0, 3) != 0); rd_addr = AW'(ra);
            cycle();
            wr_valid = 0; rd_valid = 0;
            tests_run++;
            if (rd_valid_q !== 1'(m_rd_valid) || rd_data !== m_rd_data) begin
                fails++; $display("FAIL rand_rw k=%0d addr=%0d got v=%0b d=%h exp v=%0b d=%h", k, ra, rd_valid_q, rd_data, m_rd_valid, m_rd_data);
            end
        end
        $display("[TB] test_random_rw done, %0d transactions", iters);
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < N; i++) wr_cycle(i, {$urandom, $urandom} | 64'h1);
        cfg_ready = 0; wr_cycle(COMMIT_A, 64'd0);
        rd_cycle(0);
        @(negedge clk);
        rst_n = 0;
        #1;
        tests_run++; if (cfg_valid !== 1'b0 || busy !== 1'b0 || done_irq !== 1'b0 || rd_valid_q !== 1'b0) begin fails++; $display("FAIL async_reset_ctrl got v=%0b b=%0b i=%0b r=%0b exp 0", cfg_valid, busy, done_irq, rd_valid_q); end
        tests_run++; if (cfg_data !== '0 || rd_data !== 64'd0 || wr_ready !== 1'b1) begin fails++; $display("FAIL async_reset_data got cfg=%h rd=%h exp 0", cfg_data, rd_data); end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < N; i++) begin
            rd_cycle(i);
            tests_run++; if (rd_data !== 64'd0 || done_irq !== 1'b0) begin fails++; $display("FAIL post_reset_word%0d got %h exp 0", i, rd_data); end
        end
        rd_cycle(COMMIT_A);
        tests_run++; if (rd_data !== 64'd0) begin fails++; $display("FAIL post_reset_status got %h exp 0", rd_data); end
        $display("[TB] test_reset_mid_run done");
    endtask

    initial begin
        rst_n = 0; wr_valid = 0; wr_addr = '0; wr_data = '0;
        rd_valid = 0; rd_addr = '0; cfg_ready = 0; acc_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        test_reset();
        test_basic_commit();
        test_completion(1);
        test_backpressure();
        test_completion(3);
        test_errors();
        test_stray_done();
        test_random_rw(40);
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
